// File: rtl/fnn_pkg.sv
// Shared types and defaults for the neuron datapath blocks.
package fnn_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  // Sequencer pass state.
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/neuron_weight_sequencer_if.sv
// Activation input stream and MAC-side output stream of the weight sequencer.
interface neuron_weight_sequencer_if #(
  parameter int unsigned DataWidth = fnn_pkg::DATA_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [DataWidth-1:0] out_weight;
  logic [DataWidth-1:0] out_act;
  logic                 out_first;
  logic                 out_last;

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_weight, out_act, out_first, out_last
  );

  // Activation producer / MAC consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_weight, out_act, out_first, out_last
  );

endinterface

// File: rtl/neuron_weight_sequencer.sv
// Walks one neuron's weight memory, pairing each weight with an incoming activation, and
// gates configuration writes to the memory while no pass is running.
module neuron_weight_sequencer
  import fnn_pkg::*;
#(
  parameter int unsigned NumWeight = 30,
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AddrWidth = $clog2(NumWeight)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  neuron_weight_sequencer_if.slave bus,
  output logic                 mem_ren,
  output logic [AddrWidth-1:0] mem_radd,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 mem_wen,
  output logic [AddrWidth-1:0] mem_wadd,
  output logic [DataWidth-1:0] mem_win,
  input  logic                 cfg_wen,
  input  logic [AddrWidth-1:0] cfg_addr,
  input  logic [DataWidth-1:0] cfg_data,
  output logic                 cfg_ready
);

  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumWeight - 1);

  seq_state_t           state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 pair_valid_q, pair_valid_d;
  logic [DataWidth-1:0] act_q, act_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 accept;
  logic                 at_last;

  // A new pair may enter only when the stage is empty or draining this cycle.
  assign bus.in_ready = (state_q == FETCH) && (!pair_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_last      = (cnt_q == LastIdx);

  // Memory reads only on accept, so the registered read data holds through MAC stalls.
  assign mem_ren  = accept;
  assign mem_radd = cnt_q;

  assign bus.out_valid  = pair_valid_q;
  assign bus.out_weight = mem_rdata;
  assign bus.out_act    = act_q;
  assign bus.out_first  = first_q;
  assign bus.out_last   = last_q;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_ready = (state_q == IDLE);

  // Config writes pass straight through, dropped outside IDLE.
  assign mem_wen  = cfg_wen && cfg_ready;
  assign mem_wadd = cfg_addr;
  assign mem_win  = cfg_data;

  // Next-state: pair stage, beat counter and pass FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pair_valid_d = pair_valid_q;
    act_d        = act_q;
    first_d      = first_q;
    last_d       = last_q;

    if (accept) begin
      act_d        = bus.in_data;
      pair_valid_d = 1'b1;
      first_d      = (cnt_q == '0);
      last_d       = at_last;
      // Saturate so no address past the last weight is ever presented.
      if (!at_last) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.out_ready) begin
      pair_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (accept && at_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pair_valid_q || bus.out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pair_valid_q <= 1'b0;
      act_q        <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pair_valid_q <= pair_valid_d;
      act_q        <= act_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// Scoreboard bench for neuron_weight_sequencer with a registered-read weight memory model.
module tb_neuron_weight_sequencer;
  import fnn_pkg::*;

  localparam int unsigned NW = 30;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = $clog2(NW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, busy, done;
  logic          mem_ren, mem_wen, cfg_wen, cfg_ready;
  logic [AW-1:0] mem_radd, mem_wadd, cfg_addr;
  logic [DW-1:0] mem_rdata, mem_win, cfg_data;

  neuron_weight_sequencer_if #(.DataWidth(DW)) bus ();

  neuron_weight_sequencer #(
    .NumWeight(NW),
    .DataWidth(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bus      (bus),
    .mem_ren  (mem_ren),
    .mem_radd (mem_radd),
    .mem_rdata(mem_rdata),
    .mem_wen  (mem_wen),
    .mem_wadd (mem_wadd),
    .mem_win  (mem_win),
    .cfg_wen  (cfg_wen),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready)
  );

  // Weight memory model: registered read.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_wadd] <= mem_win;
    if (mem_ren) mem_rdata <= mem[mem_radd];
  end

  typedef struct packed {
    logic [DW-1:0] w;
    logic [DW-1:0] a;
    logic          f;
    logic          l;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] exp_mem [NW];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            cyc = 0;
  int            beat_seen = 0;
  bit            stall_arm = 1'b0;
  int            stall_left = 0;
  logic [DW-1:0] hold_w, hold_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_first"}, bus.out_first, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_mem_ren"}, mem_ren, 0);
    check({tag, "_mem_wen"}, mem_wen, 0);
    check({tag, "_mem_radd"}, mem_radd, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  // MAC sink and monitor: drives out_ready (with optional stall) and scores every beat.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
      end else if (stall_arm && bus.out_valid && beat_seen == 7) begin
        stall_arm     = 1'b0;
        stall_left    = 5;
        hold_w        = bus.out_weight;
        hold_a        = bus.out_act;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (!bus.out_ready) begin
        check("stall_weight_hold", bus.out_weight, hold_w);
        check("stall_act_hold", bus.out_act, hold_a);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_mem_ren", mem_ren, 0);
        stall_left--;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_beat: got weight %0h act %0h, expected no beat",
                   bus.out_weight, bus.out_act);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_weight", bus.out_weight, e.w);
          check("beat_act", bus.out_act, e.a);
          check("beat_first", bus.out_first, e.f);
          check("beat_last", bus.out_last, e.l);
        end
        beat_seen++;
      end
    end
  end

  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cfg_wen  = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    #1;
    check("cfg_mem_wen", mem_wen, 1);
    check("cfg_mem_wadd", mem_wadd, a);
    check("cfg_mem_win", mem_win, d);
    @(negedge clk);
    cfg_wen = 1'b0;
  endtask

  task automatic run_pass(input int act_base, input bit gaps, input bit stall, input bit cfg_mid,
                          input bit restart_mid, input int reset_at, input int exp_lat);
    int k = 0;
    int iter = 0;
    int s;
    int t;
    int dones = 0;
    bit aborted = 1'b0;
    sb.delete();
    for (int i = 0; i < int'(NW); i++) begin
      sb.push_back(beat_t'{w: exp_mem[i], a: DW'(act_base + i), f: (i == 0),
                           l: (i == int'(NW) - 1)});
    end
    beat_seen = 0;
    stall_arm = stall;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (k < int'(NW) && iter < 1000) begin
      iter++;
      if (k == reset_at) begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midpass_reset");
        rst_n = 1'b1;
        sb.delete();
        aborted = 1'b1;
        break;
      end
      start        = restart_mid && (k == 10);
      cfg_wen      = cfg_mid && (k == 3);
      cfg_addr     = AW'(5);
      cfg_data     = 16'h1234;
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = DW'(act_base + k);
      #1;
      if (cfg_wen) check("cfg_blocked_mem_wen", mem_wen, 0);
      if (bus.in_valid && bus.in_ready) begin
        check("accept_mem_ren", mem_ren, 1);
        check("accept_mem_radd", mem_radd, k);
        k++;
      end
      @(negedge clk);
    end
    start        = 1'b0;
    cfg_wen      = 1'b0;
    bus.in_valid = 1'b0;
    if (iter >= 1000) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: got %0d accepts, expected %0d", k, NW);
    end
    if (aborted) begin
      for (t = 0; t < 40; t++) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("no_done_after_reset", dones, 0);
      return;
    end
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done pulse", t);
    end else begin
      if (exp_lat >= 0) check("done_latency", cyc - s, exp_lat);
      check("busy_at_done", busy, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end
    check("beats_seen", beat_seen, NW);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    cfg_wen      = 1'b0;
    cfg_addr     = '0;
    cfg_data     = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Preload mem[i] = i + 100 through the config port.
    for (int i = 0; i < int'(NW); i++) begin
      exp_mem[i] = DW'(i + 100);
      cfg_write(AW'(i), exp_mem[i]);
    end

    run_pass(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32);    // clean pass, activations 1..30
    run_pass(101, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);  // MAC stall after beat 7
    run_pass(201, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);  // gappy activations

    cfg_write(AW'(5), 16'hABCD);
    exp_mem[5] = 16'hABCD;

    run_pass(301, 1'b0, 1'b0, 1'b1, 1'b1, -1, 32);  // blocked cfg + ignored restart
    run_pass(401, 1'b0, 1'b0, 1'b0, 1'b0, 12, -1);  // reset at beat 12
    run_pass(501, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32);  // clean pass after reset

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/neuron_weight_sequencer.md
# neuron_weight_sequencer

Controller that sequences one neuron's weight memory through a full multiply-accumulate pass. On `start` it walks read addresses 0..numWeight-1, pairs each registered weight with one incoming activation through a valid/ready handshake, and presents aligned (weight, activation, first, last) beats to the neuron's MAC. It also arbitrates the memory's write port, admitting configuration writes only while no pass is active. One instance sits between each weight memory and its neuron datapath.

## Interface
- `numWeight`, 30, weights per neuron, which is also the number of activations per pass
- `addressWidth`, $clog2(numWeight), memory address width
- `dataWidth`, 16, width of weights and activations, in two's complement
- `clk`  in  1  clock; all logic is on the rising edge
- `rst_n`  in  1  reset; synchronous and active-low
- `start`  in  1  pulse that begins a pass; ignored unless the state is IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `in_valid`, `in_ready`  in/out  1  activation handshake
- `in_data`  in  dataWidth  activation
- `out_valid`, `out_ready`  out/in  1  MAC-side handshake
- `out_weight`, `out_act`  out  dataWidth  the paired operands
- `out_first`, `out_last`  out  1  beat index is 0 / beat index is numWeight-1
- `mem_ren`  out  1  memory read enable
- `mem_radd`  out  addressWidth  memory read address
- `mem_rdata`  in  dataWidth  memory read data; registered, valid 1 cycle after `mem_ren`
- `mem_wen`  out  1  memory write enable
- `mem_wadd`  out  addressWidth  memory write address
- `mem_win`  out  dataWidth  memory write data
- `cfg_wen`  in  1  configuration write request
- `cfg_addr`  in  addressWidth  configuration write address
- `cfg_data`  in  dataWidth  configuration write data
- `cfg_ready`  out  1  high only in IDLE

## Operation
- States:
  - IDLE: `start` moves to FETCH and clears `cnt`.
  - FETCH: moves to DRAIN on the accept at `cnt`=numWeight-1.
  - DRAIN: moves to DONE when the pair stage is empty, or when its last beat is accepted.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Accept rule: `in_ready` = (state==FETCH) && (!pair_valid || out_ready). An accept occurs when `in_valid` && `in_ready`.
- On an accept, in the same cycle:
  - assert `mem_ren` with `mem_radd`=`cnt`;
  - set `act_q` to `in_data`, `pair_valid` to 1, `first_q` to (`cnt`==0), `last_q` to (`cnt`==numWeight-1);
  - increment `cnt`.
- Output stage:
  - `out_valid`=`pair_valid`, `out_weight`=`mem_rdata`, `out_act`=`act_q`.
  - `out_first` and `out_last` come from `first_q` and `last_q`.
- `mem_ren` is asserted only on an accept. The memory output therefore holds its value while the MAC stalls, so no weight buffer is needed.
- `pair_valid` clears when `out_ready` is high and no new accept occurs in that cycle.
- Configuration writes:
  - `mem_wen` = `cfg_wen` && `cfg_ready`; `mem_wadd` = `cfg_addr`; `mem_win` = `cfg_data`, all combinational.
  - `cfg_wen` outside IDLE is dropped. The requester must hold it until `cfg_ready` is high.
- `start` asserted while `busy` is high has no effect.
- `cnt` never exceeds numWeight-1, and no address of numWeight or above is ever issued.

## Timing
- Reset values:
  - outputs: `busy`, `done`, `in_ready`, `out_valid`, `out_first`, `out_last`, `mem_ren`, `mem_wen` all 0; `mem_radd`=0; `cfg_ready`=1;
  - internal: state IDLE, `cnt`=0, `pair_valid`=0, `act_q`=0.
- Reset asserted mid-pass aborts the pass immediately, with no `done` pulse. Memory contents are untouched.
- Latency:
  - an accept in cycle N gives `out_valid` in cycle N+1;
  - `start` in cycle N gives `in_ready` in cycle N+1.
- With `in_valid` and `out_ready` held high, the block sustains one beat per cycle. A pass then takes 1 + numWeight + 1 cycles from `start` to `done`, i.e. 32 for the default.
- An accept and an output acceptance may occur in the same cycle; the pair stage stays full.
- `done` rises one cycle after the last beat handshakes. `busy` falls one cycle after that.

## Structure
- Shared package `fnn_pkg`:
  - `seq_state_t` enum: IDLE, FETCH, DRAIN, DONE;
  - default `DATA_WIDTH`=16.
- The block is a single module. The pair stage is about 20 lines and stays inline; no sub-module is natural.
- The bench pairs the block with the existing weight-memory model, which has a registered read.

## Test plan
- Full pass, memory preloaded with mem[i]=i+100, activations 1..30, no stalls:
  - 30 beats with `out_weight`=100..129;
  - `out_first` set only on beat 0 and `out_last` only on beat 29;
  - `done` in cycle 32 after `start`.
- `out_ready` low for 5 cycles mid-pass (after beat 7 is presented):
  - `out_weight` and `out_act` hold stable;
  - `in_ready`=0 and `mem_ren`=0 throughout;
  - beat 8 follows with the correct weight.
- `in_valid` toggled 1/0 at random: the beat sequence and weights are identical to the no-stall case, with no duplicated or skipped address.
- `cfg_wen` to address 5 with data 16'hABCD:
  - in IDLE it produces a `mem_wen` pulse, and the next pass shows 16'hABCD on beat 5;
  - issued during FETCH it gives `mem_wen`=0 and memory is unchanged.
- `start` re-pulsed during FETCH: ignored, and `cnt` is not reset.
- `rst_n` low at beat 12:
  - all outputs reach their reset values on the next edge and no `done` occurs;
  - a following `start` runs a clean 30-beat pass.
